// File: rtl/multdiv_ctrl_if.sv
// Bundle between the execute stage, the iterative multiply/divide units and the
// writeback port of multdiv_ctrl. The slave modport is the controller's view.
interface multdiv_ctrl_if;
  // Issue side: start_* are sampled only while the controller is idle.
  logic        start_mult;
  logic        start_div;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [4:0]  dest_in;
  // Unit side: one-cycle start pulses, held operands, and per-unit results.
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] unit_operandA;
  logic [31:0] unit_operandB;
  logic [31:0] mult_result;
  logic        mult_exception;
  logic        mult_resultRDY;
  logic [31:0] div_result;
  logic        div_exception;
  logic        div_resultRDY;
  // Writeback handshake: wb_valid stays high with wb_dest/wb_data/wb_exception
  // frozen until a cycle with wb_ack high; the transfer completes on that edge
  // and wb_ack has no effect while wb_valid is low.
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        wb_exception;
  logic        wb_ack;
  logic [1:0]  state_dbg;

  modport master (
    output start_mult, start_div, opA, opB, dest_in,
    output mult_result, mult_exception, mult_resultRDY,
    output div_result, div_exception, div_resultRDY, wb_ack,
    input  ctrl_MULT, ctrl_DIV, unit_operandA, unit_operandB,
    input  busy, wb_valid, wb_dest, wb_data, wb_exception, state_dbg
  );

  modport slave (
    input  start_mult, start_div, opA, opB, dest_in,
    input  mult_result, mult_exception, mult_resultRDY,
    input  div_result, div_exception, div_resultRDY, wb_ack,
    output ctrl_MULT, ctrl_DIV, unit_operandA, unit_operandB,
    output busy, wb_valid, wb_dest, wb_data, wb_exception, state_dbg
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// Sequences one MULT/DIV at a time: latch, pulse the unit, wait for resultRDY
// (bounded by a watchdog), then hold the writeback until it is acknowledged.
module multdiv_ctrl #(
  parameter int TIMEOUT = 40  // must be >= 34 to cover the slowest unit
) (
  input logic           clock,
  input logic           resetn,
  multdiv_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  state_t        state;
  logic [1:0]    op;
  logic [4:0]    dest;
  logic [CW-1:0] wdog;
  logic          ctrl_mult_q;
  logic          ctrl_div_q;
  logic [31:0]   opa_q;
  logic [31:0]   opb_q;
  logic          busy_q;
  logic          wb_valid_q;
  logic [4:0]    wb_dest_q;
  logic [31:0]   wb_data_q;
  logic          wb_exc_q;

  logic          sel_rdy;
  logic          sel_exc;
  logic [31:0]   sel_result;
  logic [CW-1:0] wdog_next;
  logic          timed_out;
  logic          cap_exc;

  // Only the unit that was actually started is listened to.
  always_comb begin
    sel_rdy    = 1'b0;
    sel_exc    = 1'b0;
    sel_result = '0;
    if (op == OP_MUL) begin
      sel_rdy    = bus.mult_resultRDY;
      sel_exc    = bus.mult_exception;
      sel_result = bus.mult_result;
    end else if (op == OP_DIV) begin
      sel_rdy    = bus.div_resultRDY;
      sel_exc    = bus.div_exception;
      sel_result = bus.div_result;
    end
  end

  // Comparing the incremented count puts the forced DONE in cycle TIMEOUT+2.
  assign wdog_next = wdog + 1'b1;
  assign timed_out = (wdog_next == TIMEOUT_C);
  assign cap_exc   = sel_rdy ? sel_exc : 1'b1;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      op          <= 2'b00;
      dest        <= '0;
      wdog        <= '0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      busy_q      <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_dest_q   <= '0;
      wb_data_q   <= '0;
      wb_exc_q    <= 1'b0;
    end else begin
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start_mult || bus.start_div) begin
            op          <= bus.start_mult ? OP_MUL : OP_DIV;
            opa_q       <= bus.opA;
            opb_q       <= bus.opB;
            dest        <= bus.dest_in;
            ctrl_mult_q <= bus.start_mult;
            ctrl_div_q  <= !bus.start_mult;
            busy_q      <= 1'b1;
            state       <= S_START;
          end
        end
        S_START: begin
          wdog  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          wdog <= wdog_next;
          if (sel_rdy || timed_out) begin
            wb_exception_capture: begin
              wb_exc_q  <= cap_exc;
              wb_dest_q <= cap_exc ? 5'd30 : dest;
              wb_data_q <= cap_exc ? ((op == OP_MUL) ? 32'd4 : 32'd5) : sel_result;
            end
            wb_valid_q <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.wb_ack) begin
            wb_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ctrl_MULT     = ctrl_mult_q;
  assign bus.ctrl_DIV      = ctrl_div_q;
  assign bus.unit_operandA = opa_q;
  assign bus.unit_operandB = opb_q;
  assign bus.busy          = busy_q;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_dest       = wb_dest_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.wb_exception  = wb_exc_q;
  assign bus.state_dbg     = state;
endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencing controller between the execute stage and the iterative multiply and divide units. It latches an issued MULT/DIV operation and fires a one-cycle `ctrl_MULT`/`ctrl_DIV` start pulse with held operands. It waits for the unit's `resultRDY`, stalls the pipeline meanwhile, and presents the result (or an rstatus exception write) on a valid/ack writeback handshake. A watchdog turns a missing `resultRDY` into an exception instead of a hang.

## Interface
- `TIMEOUT`, default 40: maximum WAIT cycles before a forced exception; must be ≥ 34.
- `clock`  in  1  sole clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start_mult`  in  1  issue a multiply; sampled only in IDLE.
- `start_div`  in  1  issue a divide; sampled only in IDLE.
- `opA`, `opB`  in  32 each  operands (dividend/divisor for DIV).
- `dest_in`  in  5  destination register number.
- `ctrl_MULT`, `ctrl_DIV`  out  1 each  one-cycle start pulse to the multiplier or divider.
- `unit_operandA`, `unit_operandB`  out  32 each  latched operands, stable from START until the return to IDLE.
- `mult_result`  in  32  multiplier result.
- `mult_exception`  in  1  multiplier exception flag.
- `mult_resultRDY`  in  1  multiplier ready.
- `div_result`  in  32  divider result.
- `div_exception`  in  1  divider exception flag.
- `div_resultRDY`  in  1  divider ready.
- `busy`  out  1  pipeline stall request.
- `wb_valid`  out  1  writeback pending.
- `wb_dest`  out  5  writeback register.
- `wb_data`  out  32  writeback value.
- `wb_exception`  out  1  writeback is an rstatus exception write.
- `wb_ack`  in  1  writeback accepted.

## Operation
- States: IDLE, START, WAIT, DONE. Two-bit op register: MUL or DIV.
- IDLE:
  - If `start_mult` or `start_div` is high, latch `opA`, `opB`, `dest_in` and the op type, then go to START.
  - If both are high, MUL wins and `start_div` is dropped.
- START:
  - Drive exactly one of `ctrl_MULT`/`ctrl_DIV` high for this single cycle.
  - Clear the watchdog counter, then go to WAIT.
- WAIT:
  - Sample only the selected unit's `resultRDY`; the other unit's signals are ignored.
  - Increment the watchdog counter every cycle.
  - On RDY = 1: capture the result and exception, then go to DONE.
  - When the counter equals TIMEOUT with no RDY: force the exception, then go to DONE.
- Capture rules:
  - No exception: `wb_dest` = latched dest, `wb_data` = unit result, `wb_exception` = 0.
  - Exception (unit flag or timeout): `wb_dest` = 30, `wb_data` = 4 for MUL or 5 for DIV, `wb_exception` = 1.
  - A latched dest of 0 is still written back unchanged; the register file discards r0.
- DONE:
  - `wb_valid` = 1; all `wb_*` outputs are held stable.
  - On `wb_ack` = 1, go to IDLE.
- `busy` = 1 in START, WAIT and DONE; 0 in IDLE.
- `start_*` is ignored in every state other than IDLE; no queueing.
- `unit_operand*` are registers; they change only on the IDLE→START edge.

## Timing
- Reset values (async, immediate): state IDLE, `ctrl_MULT` = `ctrl_DIV` = 0, `busy` = 0, `wb_valid` = 0, `wb_dest` = 0, `wb_data` = 0, `wb_exception` = 0, `unit_operand*` = 0, watchdog = 0.
- Reset asserted in any state aborts the operation; no writeback is produced.
- Cycle numbering from a start sampled at the end of cycle 0:
  - Cycle 1 (START): start pulse high.
  - Cycles 2…: WAIT.
- The unit counter clears on the edge closing cycle 1, so RDY in cycle 2 is already fresh. Stale RDY seen during cycle 1 is ignored by construction.
- Multiply: RDY arrives in cycle 18, `wb_valid` in cycle 19. Start-to-`wb_valid` latency is 19 cycles.
- Divide: `wb_valid` = 1 cycle after RDY is first seen in WAIT.
- Watchdog: with RDY never asserted, `wb_valid` rises in cycle TIMEOUT+2.
- `wb_ack` high in the first DONE cycle → IDLE next cycle. A new start is accepted in that IDLE cycle at the earliest; back-to-back issue period is 20 cycles for MUL.
- `wb_ack` outside DONE has no effect.

## Test plan
- MUL 7 × −3 (`opB` = 0xFFFFFFFD), dest 9 → `ctrl_MULT` pulse exactly in cycle 1; `wb_valid` in cycle 19 with dest 9, data 0xFFFFFFEB, `wb_exception` = 0; `busy` high in cycles 1–19.
- MUL 0x00010000 × 0x00010000, unit flags exception → `wb_dest` = 30, `wb_data` = 4, `wb_exception` = 1.
- DIV 5 / 0 with `div_exception` = 1 → `wb_dest` = 30, `wb_data` = 5; `ctrl_MULT` never pulses.
- Hold `wb_ack` = 0 for 10 cycles in DONE while pulsing `start_mult` → outputs stable, `busy` = 1, no new `ctrl_MULT`; ack → IDLE next cycle.
- `start_mult` and `start_div` together with RDY lines tied 0 → MUL selected; forced exception (dest 30, data 4) at cycle TIMEOUT+2.
- `resetn` low mid-WAIT (cycle 10) → all outputs reset immediately; no `wb_valid` afterward; a fresh MUL then completes normally.
